// File: rtl/sar_search_if.sv
// Handshake bundle between the successive-approximation controller and its
// external comparator / requester.
interface sar_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] guess;
    logic             guess_valid;
    logic             cmp_valid;
    logic             cmp_eq;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             eq_hit;
    logic             err;

    modport master (
        input  start,
        input  cmp_valid,
        input  cmp_eq,
        input  cmp_gt,
        input  cmp_lt,
        output guess,
        output guess_valid,
        output busy,
        output done,
        output result,
        output eq_hit,
        output err
    );

    modport slave (
        output start,
        output cmp_valid,
        output cmp_eq,
        output cmp_gt,
        output cmp_lt,
        input  guess,
        input  guess_valid,
        input  busy,
        input  done,
        input  result,
        input  eq_hit,
        input  err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: walks one trial bit per comparator
// transfer from MSB to LSB, stopping early on equality or on a malformed response.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sar_search_if.master bus
);
    localparam int KW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    k_d;
    logic             eq_hit_q;
    logic             eq_hit_d;
    logic             err_q;
    logic             err_d;

    logic [WIDTH-1:0] trial_bit;
    logic [WIDTH-1:0] trial;
    logic             xfer;
    logic             resp_onehot;
    logic             last_step;
    logic             finish;

    logic [WIDTH-1:0] guess_c;
    logic             guess_valid_c;
    logic             busy_c;
    logic             done_c;

    always_comb begin
        trial_bit      = '0;
        trial_bit[k_q] = 1'b1;
    end

    assign trial     = work_q | trial_bit;
    assign xfer      = (state_q == PROBE) && bus.cmp_valid;
    assign last_step = (k_q == '0);

    // Exactly one of eq/gt/lt may be set; anything else aborts the search.
    assign resp_onehot = ({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} == 3'b100) ||
                         ({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} == 3'b010) ||
                         ({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} == 3'b001);

    assign finish = xfer && (!resp_onehot || bus.cmp_eq || last_step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = PROBE;
            PROBE:   if (finish)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        guess_c       = '0;
        guess_valid_c = 1'b0;
        busy_c        = 1'b0;
        done_c        = 1'b0;
        case (state_q)
            PROBE: begin
                guess_c       = trial;
                guess_valid_c = 1'b1;
                busy_c        = 1'b1;
            end
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        work_d   = work_q;
        k_d      = k_q;
        result_d = result_q;
        eq_hit_d = eq_hit_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d   = '0;
                    k_d      = KW'(WIDTH - 1);
                    result_d = '0;
                    eq_hit_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            PROBE: begin
                if (xfer) begin
                    if (!resp_onehot) begin
                        err_d    = 1'b1;
                        eq_hit_d = 1'b0;
                        result_d = work_q;
                    end else if (bus.cmp_eq) begin
                        eq_hit_d = 1'b1;
                        result_d = trial;
                    end else begin
                        // gt keeps the trial bit, lt drops it.
                        if (bus.cmp_gt) work_d = trial;
                        if (last_step) begin
                            result_d = bus.cmp_gt ? trial : work_q;
                        end else begin
                            k_d = k_q - KW'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            k_q      <= KW'(WIDTH - 1);
            result_q <= '0;
            eq_hit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            work_q   <= work_d;
            k_q      <= k_d;
            result_q <= result_d;
            eq_hit_q <= eq_hit_d;
            err_q    <= err_d;
        end
    end

    assign bus.guess       = guess_c;
    assign bus.guess_valid = guess_valid_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.result      = result_q;
    assign bus.eq_hit      = eq_hit_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: directed and random searches against a closed-form
// model of the expected probe sequence, result and completion time.
module tb_sar_search_ctrl;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    int   prev_res;
    int   prev_eq;
    int   prev_err;

    sar_search_if #(.WIDTH(WIDTH)) bus ();

    sar_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Probes needed: the search stops once the trial bit reaches the target's lowest set bit.
    function automatic int n_xfers(input int t);
        for (int b = 0; b < WIDTH; b++) if (t[b]) return WIDTH - b;
        return WIDTH;
    endfunction

    // Value of the bits already decided before probe p: target truncated above the trial bit.
    function automatic int work_before(input int t, input int p);
        int bi;
        bi = WIDTH - 1 - p;
        if (bi < 0) return t;
        return t & ~((1 << (bi + 1)) - 1);
    endfunction

    function automatic int guess_at(input int t, input int p);
        int bi;
        bi = WIDTH - 1 - p;
        if (bi < 0) return 0;
        return work_before(t, p) | (1 << bi);
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, "_guess"}, bus.guess, 0);
        check({tag, "_gvalid"}, bus.guess_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_eq_hit"}, bus.eq_hit, 0);
        check({tag, "_err"}, bus.err, 0);
    endtask

    task automatic do_search(input int tgt, input int dly, input int bad_at,
                             input int abort_at, input bit junk);
        int n, exp_done, exp_res, exp_eq, exp_err, p, w, g;
        bit seen;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_gvalid", bus.guess_valid, 0);
        check("idle_done", bus.done, 0);
        check("idle_result_held", bus.result, prev_res);
        check("idle_eq_held", bus.eq_hit, prev_eq);
        check("idle_err_held", bus.err, prev_err);
        n = n_xfers(tgt);
        if (bad_at >= 0 && bad_at < n) begin
            exp_res  = work_before(tgt, bad_at);
            exp_eq   = 0;
            exp_err  = 1;
            exp_done = (bad_at + 1) * (dly + 1) + 1;
        end else begin
            bad_at   = -1;
            exp_res  = tgt;
            exp_eq   = (tgt != 0) ? 1 : 0;
            exp_err  = 0;
            exp_done = n * (dly + 1) + 1;
        end
        bus.start     = 1'b1;
        bus.cmp_valid = 1'($urandom);
        {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} = 3'($urandom);
        p    = 0;
        w    = 0;
        seen = 1'b0;
        for (int c = 1; c <= exp_done + 8 && !seen; c++) begin
            @(negedge clk);
            bus.start = junk ? 1'($urandom) : 1'b0;
            if (bus.done) begin
                seen          = 1'b1;
                bus.start     = 1'b0;
                bus.cmp_valid = 1'b0;
                check("done_cycle", c, exp_done);
                check("done_result", bus.result, exp_res);
                check("done_eq_hit", bus.eq_hit, exp_eq);
                check("done_err", bus.err, exp_err);
                check("done_busy", bus.busy, 0);
                check("done_gvalid", bus.guess_valid, 0);
                prev_res = exp_res;
                prev_eq  = exp_eq;
                prev_err = exp_err;
            end else begin
                g = guess_at(tgt, p);
                check("probe_busy", bus.busy, 1);
                check("probe_gvalid", bus.guess_valid, 1);
                check("probe_guess", bus.guess, g);
                if (p == abort_at) begin
                    bus.cmp_valid = 1'b0;
                    bus.start     = 1'b0;
                    #2 rst_n = 1'b0;
                    #1 check_cleared("async_rst");
                    for (int r = 0; r < 3; r++) begin
                        @(negedge clk);
                        check("rst_no_done", bus.done, 0);
                    end
                    rst_n    = 1'b1;
                    prev_res = 0;
                    prev_eq  = 0;
                    prev_err = 0;
                    return;
                end
                if (w < dly) begin
                    bus.cmp_valid = 1'b0;
                    {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} = 3'($urandom);
                    w++;
                end else begin
                    bus.cmp_valid = 1'b1;
                    if (p == bad_at)
                        {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} = 3'b011;
                    else if (tgt == g)
                        {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} = 3'b100;
                    else if (tgt > g)
                        {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} = 3'b010;
                    else
                        {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} = 3'b001;
                    p++;
                    w = 0;
                end
            end
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        int t, n, bad;
        tests    = 0;
        failed   = 0;
        prev_res = 0;
        prev_eq  = 0;
        prev_err = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.cmp_valid = 1'b0;
        bus.cmp_eq    = 1'b0;
        bus.cmp_gt    = 1'b0;
        bus.cmp_lt    = 1'b0;
        #1 check_cleared("reset");
        @(negedge clk);
        bus.start     = 1'b1;
        bus.cmp_valid = 1'b1;
        @(negedge clk);
        check_cleared("reset_hold");
        bus.start     = 1'b0;
        bus.cmp_valid = 1'b0;
        rst_n         = 1'b1;

        do_search(5, 0, -1, -1, 1'b0);
        do_search(8, 0, -1, -1, 1'b0);
        do_search(0, 0, -1, -1, 1'b0);
        do_search(13, 3, -1, -1, 1'b0);
        do_search(12, 0, 1, -1, 1'b0);
        do_search(10, 0, -1, 2, 1'b0);
        do_search(3, 0, -1, -1, 1'b0);
        do_search(15, 1, -1, -1, 1'b1);

        for (int i = 0; i < 16; i++) begin
            t   = $urandom_range(0, (1 << WIDTH) - 1);
            n   = n_xfers(t);
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            do_search(t, $urandom_range(0, 2), bad, -1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/sar_search_ctrl.md
SAR_SEARCH_CTRL -- requirements
Module: sar_search_ctrl

Interface
REQ-001: Parameter WIDTH, default 4: width of the searched value; legal range 2..16.
REQ-002: One clock; reset is asynchronous and active-low.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: rst_n  input  1  asynchronous active-low reset.
REQ-005: start  input  1  request a new search; sampled only in IDLE.
REQ-006: guess  output  WIDTH  trial value B presented to the external comparator (its A is the unknown target).
REQ-007: guess_valid  output  1  guess is stable and a comparison is requested.
REQ-008: cmp_valid  input  1  comparator result valid; a transfer occurs on a rising edge where guess_valid and cmp_valid are both 1.
REQ-009: cmp_eq, cmp_gt, cmp_lt  input  1 each  target==guess, target>guess, target<guess.
REQ-010: busy  output  1  high in PROBE.
REQ-011: done  output  1  one-cycle pulse when a search finishes.
REQ-012: result  output  WIDTH  found value; held from done until the next accepted start.
REQ-013: eq_hit  output  1  search ended on an equality response; held with result.
REQ-014: err  output  1  search aborted on a non-one-hot response; held with result.

Function
REQ-015: The FSM SHALL have three states, IDLE, PROBE and DONE; IDLE -> PROBE on start, PROBE -> DONE on the terminating transfer, DONE -> IDLE unconditionally after one cycle.
REQ-016: On start in IDLE, the block SHALL clear the working register, set the step index k = WIDTH-1, clear eq_hit and err, and enter PROBE on the next edge.
REQ-017: In PROBE, guess SHALL equal work | (1<<k), and guess_valid SHALL be 1 continuously, with guess constant until a transfer.
REQ-018: In PROBE, cycles without cmp_valid SHALL hold all state (unbounded wait, no timeout).
REQ-019: On a transfer with cmp_eq=1 (and the others 0), the block SHALL capture result = guess, set eq_hit=1, and go to DONE, terminating early.
REQ-020: On a transfer with cmp_gt=1, the block SHALL set work = guess; on cmp_lt=1, work SHALL remain unchanged (trial bit cleared).
REQ-021: After a gt/lt transfer with k=0, the block SHALL set result = updated work, keep eq_hit=0, and go to DONE; otherwise it SHALL decrement k and stay in PROBE, presenting the new guess in the next cycle.
REQ-022: A transfer whose {cmp_eq,cmp_gt,cmp_lt} is not exactly one-hot SHALL set err=1, result = work (before update), eq_hit=0, and go to DONE.
REQ-023: The block SHALL perform at most WIDTH transfers per search; with a responder that answers every cycle, done SHALL assert exactly n+1 cycles after the start cycle, where n is the transfer count.
REQ-024: done SHALL be high only in DONE, and busy and guess_valid SHALL be 0 in IDLE and DONE.
REQ-025: start SHALL be ignored in PROBE and DONE; cmp_valid SHALL be ignored outside PROBE.
REQ-026: start asserted in the cycle after DONE (IDLE) SHALL be accepted normally, allowing back-to-back searches.

Reset
REQ-027: While rst_n=0, the block SHALL force state=IDLE, guess=0, guess_valid=0, busy=0, done=0, result=0, eq_hit=0, err=0, work=0 and k=WIDTH-1, regardless of clk.
REQ-028: Reset mid-PROBE SHALL abandon the search with no done pulse, and the first start after release SHALL begin a fresh search.

Verification (WIDTH=4, responder answers same cycle unless noted)
REQ-029: Target 5: guesses SHALL be 8(lt), 4(gt), 6(lt), 5(eq); result=5, eq_hit=1, err=0, done 5 cycles after start.
REQ-030: Target 8: a single transfer 8(eq); result=8, eq_hit=1, done 2 cycles after start.
REQ-031: Target 0: guesses SHALL be 8, 4, 2, 1, all lt; result=0, eq_hit=0, 4 transfers.
REQ-032: Target 13 with the responder delaying cmp_valid by 3 cycles per probe: guesses 8, 12, 14, 13 held stable while waiting; result=13, eq_hit=1.
REQ-033: Second probe answered with cmp_gt=cmp_lt=1: err=1, result=8 (work after the first gt), done pulses, and no further probes.
REQ-034: rst_n pulsed low during the third probe, then start with target 3: no done for the aborted search, and the new search yields result=3 with guesses 8, 4, 2, 3.
